hf_resp_timer: RTL and testbench

Parametrised reader-to-tag response timer for the HF front end. It measures, in clock cycles, the gap from the end of the last reader pause (carrier restored) to the first detected tag subcarrier modulation. Each measurement is queued as a flagged record in an internal FIFO, so the ARM can collect several frames' timings in one read burst. It is fed by the pause signal from the modulation path and the bit-rate modulation detector output, and is read by the ARM-facing readout logic.

---
 rtl/hf_resp_timer.sv | 208 ++++++++++++++++++++
 tb/tb_hf_resp_timer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hf_resp_timer.sv
// hf_resp_timer
//
// Reader-to-tag response timer for the HF front end. Counts clock cycles
// from the end of the last reader pause (carrier restored) to the first
// detected tag subcarrier modulation, and queues each measurement as a
// flagged record in a first-word-fall-through FIFO for the ARM readout.
//
// Optional feature macro: TIMER_TIMEOUT_EN
//   defined   : a measurement with no detect is closed with a timeout record
//               {1, 0, TIMEOUT} once the count reaches TIMEOUT.
//   undefined : no timeout; the counter saturates and waits for a detect,
//               carrier_off, en=0 or reset.
//
// Parameters
//   CNT_W   counter width (>= 4)
//   DEPTH   FIFO depth in records (power of two, >= 2)
//   TIMEOUT timeout limit in cycles (1 .. 2^CNT_W-1), timeout build only
//
// Ports
//   ck_1356meg   in   clock, posedge
//   nreset       in   asynchronous active-low reset
//   en           in   measurement enable
//   carrier_off  in   1 = reader pause in progress
//   mod_det      in   1 = tag modulation detected this cycle
//   rd_en        in   pop request, ignored when empty
//   rd_data      out  head record {timeout, sat, count}, 0 when empty
//   empty        out  FIFO empty
//   full         out  FIFO full
//   level        out  records held
//   drop_cnt     out  records lost to overflow, saturates at 255
//   busy         out  measurement FSM not idle
//
// State table
//   state    | meaning
//   ST_IDLE  | waiting for en=1 and a reader pause
//   ST_PAUSE | reader pause in progress, waiting for carrier restore
//   ST_COUNT | counting cycles since carrier restore, waiting for tag response

module hf_resp_timer #(
    parameter int CNT_W   = 16,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                      ck_1356meg,
    input  logic                      nreset,
    input  logic                      en,
    input  logic                      carrier_off,
    input  logic                      mod_det,
    input  logic                      rd_en,
    output logic [CNT_W+1:0]          rd_data,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    level,
    output logic [7:0]                drop_cnt,
    output logic                      busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [AW:0]      LVL_FULL = (AW+1)'(DEPTH);

    // Elaboration-time parameter sanity check.
    if (CNT_W < 4 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 ||
        longint'(TIMEOUT) > ((longint'(1) << CNT_W) - 1)) begin : g_param_err
        $error("hf_resp_timer: illegal parameter combination");
    end

`ifdef TIMER_TIMEOUT_EN
    // cnt_q is N on the edge E0+N; the count reaches TIMEOUT on the edge
    // where cnt_q is TIMEOUT-1, which is where the timeout record is pushed.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PAUSE = 2'd1,
        ST_COUNT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               busy_q, busy_d;

    logic               push;
    logic [CNT_W+1:0]   push_rec;

    // ------------------------------------------------------------------
    // Measurement FSM: next-state and record generation
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        push     = 1'b0;
        push_rec = {1'b0, sat_q, cnt_q};

        if (!en) begin
            // In-flight measurement is abandoned without a record.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (carrier_off) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (!carrier_off) begin
                        state_d = ST_COUNT;
                        cnt_d   = CNT_ONE;
                        sat_d   = 1'b0;
                    end
                end
                ST_COUNT: begin
                    if (carrier_off) begin
                        // A new pause restarts the measurement.
                        state_d = ST_PAUSE;
                    end else if (mod_det) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
`ifdef TIMER_TIMEOUT_EN
                    end else if (cnt_q >= TO_LAST) begin
                        push     = 1'b1;
                        push_rec = {1'b1, 1'b0, TO_VAL};
                        state_d  = ST_IDLE;
`endif
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q == CNT_MAX - CNT_ONE) begin
                            sat_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge ck_1356meg or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;

    // ------------------------------------------------------------------
    // Record FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [CNT_W+1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_w;
    logic             do_pop, do_push, do_drop;

    // Pointers carry one extra wrap bit so that full and empty differ.
    assign level_w = wr_ptr_q - rd_ptr_q;
    assign empty   = (level_w == '0);
    assign full    = (level_w == LVL_FULL);
    assign level   = level_w;

    // A pop while full frees the slot the simultaneous push needs.
    assign do_pop  = rd_en & ~empty;
    assign do_push = push & (~full | do_pop);
    assign do_drop = push & ~do_push;

    always_ff @(posedge ck_1356meg or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_cnt <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
            if (do_drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge ck_1356meg) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_rec;
        end
    end

    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: tb/tb_hf_resp_timer.sv
module tb_hf_resp_timer;

    localparam int W     = 6;
    localparam int DEPTH = 4;
    localparam int TO    = 50;
    localparam int MAXC  = (1 << W) - 1;

    logic           clk = 1'b0;
    logic           nreset;
    logic           en, carrier_off, mod_det, rd_en;
    logic [W+1:0]   rd_data;
    logic           empty, full, busy;
    logic [2:0]     level;
    logic [7:0]     drop_cnt;

    hf_resp_timer #(.CNT_W(W), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .ck_1356meg (clk),
        .nreset     (nreset),
        .en         (en),
        .carrier_off(carrier_off),
        .mod_det    (mod_det),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .level      (level),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int rd_pct = 0;

    // Reference model: phase of the measurement, cycle stamp of E0,
    // a queue for the FIFO and a drop counter.
    int           m_ph   = 0;   // 0 idle, 1 pause, 2 counting
    int           m_cyc  = 0;
    int           m_e0   = 0;
    int           m_drop = 0;
    logic [W+1:0] m_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_ph   = 0;
        m_drop = 0;
        m_q.delete();
    endtask

    task automatic model_step();
        int           n;
        bit           push;
        bit           pop;
        logic [W+1:0] rec;
        push = 0;
        rec  = '0;
        m_cyc++;
        if (!en) begin
            m_ph = 0;
        end else if (m_ph == 0) begin
            if (carrier_off) m_ph = 1;
        end else if (m_ph == 1) begin
            if (!carrier_off) begin
                m_ph = 2;
                m_e0 = m_cyc;
            end
        end else begin
            n = m_cyc - m_e0;
            if (carrier_off) begin
                m_ph = 1;
            end else if (mod_det) begin
                push = 1;
                rec  = {1'b0, (n >= MAXC) ? 1'b1 : 1'b0, W'((n >= MAXC) ? MAXC : n)};
                m_ph = 0;
`ifdef TIMER_TIMEOUT_EN
            end else if (n >= TO - 1) begin
                push = 1;
                rec  = {1'b1, 1'b0, W'(TO)};
                m_ph = 0;
`endif
            end
        end
        pop = rd_en && (m_q.size() > 0);
        if (push && !(m_q.size() < DEPTH || pop)) begin
            push = 0;
            if (m_drop < 255) m_drop++;
        end
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(rec);
    endtask

    task automatic check_all();
        chk("rd_data", rd_data, (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
        chk("empty", empty, (m_q.size() == 0) ? 1 : 0);
        chk("full", full, (m_q.size() == DEPTH) ? 1 : 0);
        chk("level", level, m_q.size());
        chk("drop_cnt", drop_cnt, m_drop);
        chk("busy", busy, (m_ph != 0) ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        if (rd_pct > 0) rd_en = ($urandom_range(0, 99) < rd_pct);
    endtask

    // Pause of plen cycles, then detect sampled at E0+n (optionally with a pop).
    task automatic measure(input int plen, input int n, input bit pop_at_push);
        carrier_off = 1'b1;
        repeat (plen) tick();
        carrier_off = 1'b0;
        tick();
        repeat (n - 1) tick();
        mod_det = 1'b1;
        rd_en   = pop_at_push;
        tick();
        mod_det = 1'b0;
        rd_en   = 1'b0;
    endtask

    task automatic drain();
        rd_en = 1'b1;
        repeat (DEPTH) tick();
        rd_en = 1'b0;
    endtask

    initial begin
        nreset      = 1'b0;
        en          = 1'b0;
        carrier_off = 1'b0;
        mod_det     = 1'b0;
        rd_en       = 1'b0;
        model_reset();
        #12;
        check_all();
        nreset = 1'b1;
        en     = 1'b1;
        tick();

        // Basic measurement: detect at E0+37.
        measure(3, 37, 1'b0);
        chk("basic_rec", rd_data, {2'b00, 6'd37});
        chk("basic_level", level, 1);
        tick();
        drain();

        // Re-pause restarts the measurement.
        carrier_off = 1'b1;
        repeat (2) tick();
        carrier_off = 1'b0;
        tick();
        repeat (9) tick();
        carrier_off = 1'b1;
        repeat (2) tick();
        carrier_off = 1'b0;
        tick();
        repeat (4) tick();
        mod_det = 1'b1;
        tick();
        mod_det = 1'b0;
        chk("repause_rec", rd_data, {2'b00, 6'd5});
        chk("repause_level", level, 1);
        drain();

        // Long wait: saturation, or timeout when enabled.
        measure(2, 70, 1'b0);
`ifdef TIMER_TIMEOUT_EN
        chk("long_rec", rd_data, {2'b10, 6'(TO)});
`else
        chk("long_rec", rd_data, {2'b01, 6'd63});
`endif
        chk("long_busy", busy, 0);
        drain();

        // Overflow: six measurements with no reads.
        for (int i = 0; i < 6; i++) measure(1, 3 + i, 1'b0);
        chk("ovf_full", full, 1);
        chk("ovf_level", level, 4);
        chk("ovf_drop", drop_cnt, 2);
        measure(1, 4, 1'b1);
        chk("ovf_pp_level", level, 4);
        chk("ovf_pp_drop", drop_cnt, 2);

        // en=0 mid-count: no record, busy clears.
        carrier_off = 1'b1;
        tick();
        carrier_off = 1'b0;
        tick();
        repeat (5) tick();
        en = 1'b0;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_level", level, 4);
        en = 1'b1;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("pre_rst_level", level, 3);

        // Asynchronous reset with records queued.
        #2;
        nreset = 1'b0;
        #1;
        chk("arst_empty", empty, 1);
        chk("arst_level", level, 0);
        chk("arst_drop", drop_cnt, 0);
        chk("arst_rd_data", rd_data, 0);
        model_reset();
        #2;
        nreset = 1'b1;
        tick();

        // Randomised traffic.
        for (int m = 0; m < 150; m++) begin
            int n, rp, ep;
            rd_pct = $urandom_range(0, 60);
            n  = $urandom_range(1, 90);
            rp = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 90) : 0;
            ep = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 90) : 0;
            carrier_off = 1'b1;
            repeat ($urandom_range(1, 3)) begin
                mod_det = ($urandom_range(0, 3) == 0);
                tick();
            end
            mod_det     = 1'b0;
            carrier_off = 1'b0;
            tick();
            for (int k = 1; k < n; k++) begin
                carrier_off = (k == rp);
                en          = (k != ep);
                tick();
            end
            carrier_off = 1'b0;
            en          = 1'b1;
            mod_det     = 1'b1;
            tick();
            mod_det = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        rd_pct = 0;
        rd_en  = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
